// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and
// data-memory freezes with a bounded wait, plus stall/flush counters.
module hazard_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       reg_ra_addr,
  input  logic [4:0]       reg_rb_addr,
  input  logic [4:0]       reg_rt_addr,
  input  logic             use_ra,
  input  logic             use_rb,
  input  logic             use_rt,
  input  logic             xREG2_do_dm_read,
  input  logic             xREG2_do_reg_write,
  input  logic [4:0]       xREG2_write_reg_addr,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             dm_ready,
  output logic             pc_enable,
  output logic             xREG1_enable,
  output logic             xREG2_enable,
  output logic             xREG3_enable,
  output logic             xREG1_flush,
  output logic             xREG2_bubble,
  output logic             dm_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t              state_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                dm_timeout_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q;
  logic [CNT_W-1:0]    flush_cnt_d;
  logic                load_use;
  logic                freeze;
  logic                wait_limit;

  // Decode-stage source matches the destination of a load in execute
  always_comb begin
    load_use = xREG2_do_dm_read && xREG2_do_reg_write &&
               ((use_ra && (reg_ra_addr == xREG2_write_reg_addr)) ||
                (use_rb && (reg_rb_addr == xREG2_write_reg_addr)) ||
                (use_rt && (reg_rt_addr == xREG2_write_reg_addr)));
  end

  // Freeze while memory is busy; in MEM_WAIT the wait is bounded by TIMEOUT
  always_comb begin
    wait_limit = (wait_cnt_q >= WAIT_W'(TIMEOUT));
    freeze     = 1'b0;
    case (state_q)
      RUN:      freeze = mem_req && !dm_ready;
      MEM_WAIT: freeze = !dm_ready && !wait_limit;
      default:  freeze = 1'b0;
    endcase
  end

  // Pipeline control, priority: reset, freeze, branch, load-use
  always_comb begin
    pc_enable    = 1'b1;
    xREG1_enable = 1'b1;
    xREG2_enable = 1'b1;
    xREG3_enable = 1'b1;
    xREG1_flush  = 1'b0;
    xREG2_bubble = 1'b0;
    if (reset) begin
      xREG1_flush  = 1'b1;
      xREG2_bubble = 1'b1;
    end else if (freeze) begin
      pc_enable    = 1'b0;
      xREG1_enable = 1'b0;
      xREG2_enable = 1'b0;
      xREG3_enable = 1'b0;
    end else if (branch_taken) begin
      xREG1_flush  = 1'b1;
      xREG2_bubble = 1'b1;
    end else if (load_use) begin
      pc_enable    = 1'b0;
      xREG1_enable = 1'b0;
      xREG2_bubble = 1'b1;
    end
  end

  // Saturating performance counter next values
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_enable && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (xREG1_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Memory-wait FSM with wait counter and sticky timeout flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      dm_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (freeze) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (freeze) begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            if (!dm_ready) begin
              dm_timeout_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign dm_timeout = dm_timeout_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (TIMEOUT=4, CNT_W=4 build) with a
// scoreboard of expected control vectors and counter/flag state.
module tb_hazard_unit;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;

  // Control vector order: {pc, xREG1_en, xREG2_en, xREG3_en, flush, bubble}
  localparam logic [5:0] C_NORM = 6'b111100;
  localparam logic [5:0] C_FRZ  = 6'b000000;
  localparam logic [5:0] C_BR   = 6'b111111;
  localparam logic [5:0] C_LU   = 6'b001101;
  localparam logic [5:0] C_RST  = 6'b111111;

  typedef struct packed {
    logic             to;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } stat_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       reg_ra_addr, reg_rb_addr, reg_rt_addr;
  logic             use_ra, use_rb, use_rt;
  logic             xREG2_do_dm_read, xREG2_do_reg_write;
  logic [4:0]       xREG2_write_reg_addr;
  logic             branch_taken, mem_req, dm_ready;
  logic             pc_enable, xREG1_enable, xREG2_enable, xREG3_enable;
  logic             xREG1_flush, xREG2_bubble, dm_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  logic [5:0]       q_ctl[$];
  stat_t            q_stat[$];
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  hazard_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .reg_ra_addr(reg_ra_addr), .reg_rb_addr(reg_rb_addr), .reg_rt_addr(reg_rt_addr),
    .use_ra(use_ra), .use_rb(use_rb), .use_rt(use_rt),
    .xREG2_do_dm_read(xREG2_do_dm_read), .xREG2_do_reg_write(xREG2_do_reg_write),
    .xREG2_write_reg_addr(xREG2_write_reg_addr),
    .branch_taken(branch_taken), .mem_req(mem_req), .dm_ready(dm_ready),
    .pc_enable(pc_enable), .xREG1_enable(xREG1_enable),
    .xREG2_enable(xREG2_enable), .xREG3_enable(xREG3_enable),
    .xREG1_flush(xREG1_flush), .xREG2_bubble(xREG2_bubble),
    .dm_timeout(dm_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  // One clock cycle: check combinational controls mid-cycle, then the
  // registered flag and counters just after the rising edge.
  task automatic step(input string tag, input logic [5:0] exp_ctl, input logic exp_to);
    logic [5:0] obs_ctl;
    logic [5:0] e_ctl;
    stat_t      obs_st;
    stat_t      e_st;
    q_ctl.push_back(exp_ctl);
    if (reset) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!exp_ctl[5] && (m_stall != {CNT_W{1'b1}})) m_stall = m_stall + CNT_W'(1);
      if (exp_ctl[1] && (m_flush != {CNT_W{1'b1}})) m_flush = m_flush + CNT_W'(1);
    end
    q_stat.push_back('{to: exp_to, stall: m_stall, flush: m_flush});
    #3;
    obs_ctl = {pc_enable, xREG1_enable, xREG2_enable, xREG3_enable, xREG1_flush, xREG2_bubble};
    e_ctl = q_ctl.pop_front();
    checks++;
    assert (obs_ctl === e_ctl) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs_ctl, e_ctl);
    end
    @(posedge clock);
    #1;
    obs_st = '{to: dm_timeout, stall: stall_cnt, flush: flush_cnt};
    e_st = q_stat.pop_front();
    checks++;
    assert (obs_st === e_st) else begin
      failures++;
      $error("FAIL %s stat observed to=%b stall=%0d flush=%0d expected to=%b stall=%0d flush=%0d",
             tag, obs_st.to, obs_st.stall, obs_st.flush, e_st.to, e_st.stall, e_st.flush);
    end
  endtask

  task automatic idle_inputs();
    reg_ra_addr = 5'd1; reg_rb_addr = 5'd2; reg_rt_addr = 5'd4;
    use_ra = 1'b0; use_rb = 1'b0; use_rt = 1'b0;
    xREG2_do_dm_read = 1'b0; xREG2_do_reg_write = 1'b0; xREG2_write_reg_addr = 5'd3;
    branch_taken = 1'b0; mem_req = 1'b0; dm_ready = 1'b0;
  endtask

  initial begin
    #1;
    idle_inputs();
    reset = 1'b1;
    mem_req = 1'b1;
    branch_taken = 1'b1;
    step("reset_a", C_RST, 1'b0);
    step("reset_b", C_RST, 1'b0);
    reset = 1'b0;
    idle_inputs();
    step("idle", C_NORM, 1'b0);

    // Load-use on ra, then the bubble reaches execute
    xREG2_do_dm_read = 1'b1; xREG2_do_reg_write = 1'b1; xREG2_write_reg_addr = 5'd3;
    reg_ra_addr = 5'd3; use_ra = 1'b1;
    step("lu_ra", C_LU, 1'b0);
    checks++;
    assert (stall_cnt === 4'd1) else begin
      failures++;
      $error("FAIL lu_ra_cnt observed=%0d expected=1", stall_cnt);
    end
    idle_inputs();
    step("after_lu", C_NORM, 1'b0);

    // Non-hazard variants
    xREG2_do_dm_read = 1'b1; xREG2_do_reg_write = 1'b1; reg_ra_addr = 5'd3; use_ra = 1'b0;
    step("no_use_ra", C_NORM, 1'b0);
    use_ra = 1'b1; xREG2_do_dm_read = 1'b0;
    step("not_load", C_NORM, 1'b0);
    xREG2_do_dm_read = 1'b1; xREG2_do_reg_write = 1'b0;
    step("no_write", C_NORM, 1'b0);
    xREG2_do_reg_write = 1'b1; reg_ra_addr = 5'd7;
    step("addr_miss", C_NORM, 1'b0);
    use_ra = 1'b0; reg_rb_addr = 5'd3; use_rb = 1'b1;
    step("lu_rb", C_LU, 1'b0);
    use_rb = 1'b0; xREG2_write_reg_addr = 5'd0; reg_rt_addr = 5'd0; use_rt = 1'b1;
    step("lu_rt_r0", C_LU, 1'b0);

    // Branch overrides load-use
    branch_taken = 1'b1;
    step("lu_branch", C_BR, 1'b0);
    idle_inputs();

    // Memory wait: three busy cycles then ready
    mem_req = 1'b1; dm_ready = 1'b0;
    step("mw_1", C_FRZ, 1'b0);
    branch_taken = 1'b1;
    xREG2_do_dm_read = 1'b1; xREG2_do_reg_write = 1'b1; reg_ra_addr = 5'd3; use_ra = 1'b1;
    step("mw_2_over", C_FRZ, 1'b0);
    idle_inputs(); mem_req = 1'b1;
    step("mw_3", C_FRZ, 1'b0);
    dm_ready = 1'b1;
    step("mw_done", C_NORM, 1'b0);
    checks++;
    assert (stall_cnt === 4'd6) else begin
      failures++;
      $error("FAIL mw_cnt observed=%0d expected=6", stall_cnt);
    end
    mem_req = 1'b0; dm_ready = 1'b0;
    step("mw_run", C_NORM, 1'b0);

    // Ready in the same cycle: no freeze, stays in RUN
    mem_req = 1'b1; dm_ready = 1'b1;
    step("hit", C_NORM, 1'b0);
    mem_req = 1'b0; dm_ready = 1'b0;
    step("hit_run", C_NORM, 1'b0);

    // Wait exit coinciding with a branch
    mem_req = 1'b1;
    step("mwb_1", C_FRZ, 1'b0);
    dm_ready = 1'b1; branch_taken = 1'b1;
    step("mwb_exit", C_BR, 1'b0);
    idle_inputs();

    // Timeout: exactly TIMEOUT frozen cycles, then release with sticky flag
    mem_req = 1'b1;
    for (int i = 0; i < int'(TIMEOUT); i++) step("to_frz", C_FRZ, 1'b0);
    step("to_rel", C_NORM, 1'b1);
    mem_req = 1'b0;
    step("to_hold_a", C_NORM, 1'b1);
    step("to_hold_b", C_NORM, 1'b1);
    reset = 1'b1;
    step("to_reset", C_RST, 1'b0);
    reset = 1'b0;

    // Reset in the middle of a wait abandons it without a timeout
    mem_req = 1'b1;
    step("rmw_1", C_FRZ, 1'b0);
    step("rmw_2", C_FRZ, 1'b0);
    reset = 1'b1;
    step("rmw_rst", C_RST, 1'b0);
    reset = 1'b0; mem_req = 1'b0;
    step("rmw_run", C_NORM, 1'b0);

    // Counter saturation
    xREG2_do_dm_read = 1'b1; xREG2_do_reg_write = 1'b1; reg_ra_addr = 5'd3; use_ra = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) step("sat_stall", C_LU, 1'b0);
    checks++;
    assert (stall_cnt === 4'hF) else begin
      failures++;
      $error("FAIL sat_stall_end observed=%0d expected=15", stall_cnt);
    end
    branch_taken = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) step("sat_flush", C_BR, 1'b0);
    checks++;
    assert (flush_cnt === 4'hF) else begin
      failures++;
      $error("FAIL sat_flush_end observed=%0d expected=15", flush_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of frozen cycles per data-memory access (range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the performance counters.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports reg_ra_addr, reg_rb_addr, reg_rt_addr, input, 5 bits each: source register addresses of the decode-stage instruction.
REQ-006 The block SHALL have ports use_ra, use_rb, use_rt, input, 1 bit each: the decode-stage instruction actually reads that source.
REQ-007 The block SHALL have ports xREG2_do_dm_read and xREG2_do_reg_write (input, 1 bit each) and xREG2_write_reg_addr (input, 5 bits), all describing the execute-stage instruction.
REQ-008 The block SHALL have port branch_taken, input, 1 bit: the execute-stage instruction redirects the PC this cycle.
REQ-009 The block SHALL have ports mem_req, input, 1 bit (the xREG3-stage instruction accesses data memory), and dm_ready, input, 1 bit (data memory completes this cycle).
REQ-010 The block SHALL have outputs pc_enable, xREG1_enable, xREG2_enable and xREG3_enable, 1 bit each: load enables for the PC and the pipeline registers.
REQ-011 The block SHALL have outputs xREG1_flush and xREG2_bubble, 1 bit each: clear IF/ID; load a NOP into ID/EX.
REQ-012 The block SHALL have outputs dm_timeout (1 bit, sticky memory-timeout error), stall_cnt (CNT_W bits) and flush_cnt (CNT_W bits).

Function
REQ-013 The FSM SHALL have two states, RUN and MEM_WAIT, plus an 8-bit wait_cnt register.
REQ-014 Load-use hazard SHALL be defined as xREG2_do_dm_read && xREG2_do_reg_write && any of (use_ra && reg_ra_addr==xREG2_write_reg_addr), (use_rb && reg_rb_addr==...), (use_rt && reg_rt_addr==...); register 0 is not exempt.
REQ-015 Freeze in RUN SHALL be mem_req && !dm_ready; freeze in MEM_WAIT SHALL be !dm_ready && wait_cnt<TIMEOUT.
REQ-016 Outputs under freeze (highest priority) SHALL be: all four enables 0, xREG1_flush=0, xREG2_bubble=0; branch_taken and hazard are ignored.
REQ-017 Outputs under branch_taken without freeze SHALL be: all enables 1, xREG1_flush=1, xREG2_bubble=1; load-use is ignored (wrong-path instruction).
REQ-018 Outputs under load-use hazard without freeze or branch SHALL be: pc_enable=0, xREG1_enable=0, xREG2_enable=1, xREG3_enable=1, xREG2_bubble=1, xREG1_flush=0, giving a one-cycle bubble.
REQ-019 Otherwise all enables SHALL be 1 and xREG1_flush=xREG2_bubble=0.
REQ-020 RUN->MEM_WAIT SHALL occur on a RUN freeze, with wait_cnt<=1.
REQ-021 In MEM_WAIT while frozen, wait_cnt SHALL increment.
REQ-022 MEM_WAIT->RUN SHALL occur in the first cycle dm_ready=1 or wait_cnt==TIMEOUT, with wait_cnt<=0; that cycle is unfrozen, so the maximum freeze is exactly TIMEOUT cycles.
REQ-023 On a timeout exit with dm_ready=0, dm_timeout SHALL be set to 1 and held until reset.
REQ-024 mem_req=1 && dm_ready=1 in RUN SHALL cause no freeze and no state change.
REQ-025 stall_cnt SHALL increment by 1 every cycle pc_enable==0 and saturate at all-ones.
REQ-026 flush_cnt SHALL increment by 1 every cycle xREG1_flush==1 and saturate at all-ones.
REQ-027 All control outputs SHALL be combinational from inputs and state, with zero-cycle latency.

Reset
REQ-028 With reset=1 at a clock edge, the state SHALL become RUN, wait_cnt 0, dm_timeout 0, stall_cnt 0 and flush_cnt 0.
REQ-029 While reset=1, outputs SHALL be all enables 1, xREG1_flush=1 and xREG2_bubble=1, regardless of other inputs.
REQ-030 Reset asserted mid-MEM_WAIT SHALL abandon the wait without setting dm_timeout.

Verification
REQ-031 ld r3 in execute, decode uses ra=3 (use_ra=1): one cycle with pc_enable=0, xREG2_bubble=1; stall_cnt 0->1; the next cycle is clean.
REQ-032 The same case with use_ra=0, or xREG2_do_dm_read=0: no stall.
REQ-033 Load-use together with branch_taken: xREG1_flush=1, xREG2_bubble=1, pc_enable=1; flush_cnt +1, stall_cnt unchanged.
REQ-034 mem_req=1, dm_ready low for 3 cycles then high: 3 frozen cycles, the 4th unfrozen and back in RUN; stall_cnt=3; dm_timeout=0.
REQ-035 TIMEOUT=4, mem_req=1, dm_ready never asserted: exactly 4 frozen cycles, then release with dm_timeout=1 held; reset clears it to 0.
REQ-036 Force 2^CNT_W+5 stall cycles (CNT_W=4 build): stall_cnt holds 15.
